// File: rtl/pci_initiator.sv
// PCI bus master: runs one 1-4 word read or write burst per Start and raises a master abort if DEVSEL# never arrives.
// Bus controls decode from state in the same cycle; Rd_data/Rd_valid follow a read data phase by one cycle; TRDY# wait states stall indefinitely.
module pci_initiator #(
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [3:0]  Cmd,
    input  logic [31:0] Addr,
    input  logic [1:0]  Len,
    input  logic [31:0] Wr_data,
    output logic        Wr_ack,
    output logic [31:0] Rd_data,
    output logic        Rd_valid,
    output logic        Busy,
    output logic        Done,
    output logic        Abort_err,
    output logic        REQ,
    input  logic        GNT,
    input  logic        Frame_in,
    input  logic        IRDY_in,
    output logic        Frame_out,
    output logic        Frame_oe,
    output logic        IRDY_out,
    output logic        IRDY_oe,
    input  logic        TRDY,
    input  logic        DEVSEL,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic [3:0]  CBE_out,
    output logic        CBE_oe
);
    localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_ABORT, S_TURN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cmd_q;
    logic [31:0]   addr_q;
    logic [1:0]    len_q;
    logic [1:0]    word_cnt;
    logic [CW-1:0] dev_cnt;
    logic          dev_seen;
    logic          from_abort;
    logic          is_write;
    logic          last_word;
    logic          abort_now;
    logic          xfer;

    assign is_write  = cmd_q[0];
    assign last_word = (word_cnt == len_q);
    // The abort check wins over a same-cycle TRDY# so an aborted phase never acks or captures data.
    assign abort_now = (state == S_DATA) && !dev_seen && DEVSEL &&
                       (dev_cnt == CW'(DEVSEL_TIMEOUT - 1));
    assign xfer      = (state == S_DATA) && !TRDY && !abort_now;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = S_REQ;
            S_REQ:   if (!GNT && Frame_in && IRDY_in) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_DATA;
            S_DATA: begin
                if (abort_now) begin
                    state_nxt = S_ABORT;
                end else if (xfer && last_word) begin
                    state_nxt = S_TURN;
                end
            end
            S_ABORT: state_nxt = S_TURN;
            S_TURN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            word_cnt   <= '0;
            dev_cnt    <= '0;
            dev_seen   <= 1'b0;
            from_abort <= 1'b0;
            Rd_data    <= '0;
            Rd_valid   <= 1'b0;
        end else begin
            Rd_valid   <= xfer && !is_write;
            from_abort <= (state == S_ABORT);
            if (state == S_IDLE && Start) begin
                cmd_q  <= Cmd;
                addr_q <= Addr;
                len_q  <= Len;
            end
            if (state == S_ADDR) begin
                word_cnt <= '0;
                dev_cnt  <= '0;
                dev_seen <= 1'b0;
            end else if (state == S_DATA) begin
                if (xfer) word_cnt <= word_cnt + 2'd1;
                if (!DEVSEL) begin
                    dev_seen <= 1'b1;
                end else if (!dev_seen) begin
                    dev_cnt <= dev_cnt + CW'(1);
                end
            end
            if (xfer && !is_write) Rd_data <= AD_in;
        end
    end

    always_comb begin
        REQ       = 1'b1;
        Frame_out = 1'b1;
        Frame_oe  = 1'b0;
        IRDY_out  = 1'b1;
        IRDY_oe   = 1'b0;
        AD_out    = '0;
        AD_oe     = 1'b0;
        CBE_out   = '0;
        CBE_oe    = 1'b0;
        Busy      = (state != S_IDLE);
        Done      = (state == S_TURN);
        Abort_err = (state == S_TURN) && from_abort;
        Wr_ack    = xfer && is_write;
        case (state)
            S_REQ: REQ = 1'b0;
            S_ADDR: begin
                Frame_out = 1'b0;
                Frame_oe  = 1'b1;
                IRDY_oe   = 1'b1;
                AD_out    = addr_q;
                AD_oe     = 1'b1;
                CBE_out   = cmd_q;
                CBE_oe    = 1'b1;
            end
            S_DATA: begin
                Frame_out = last_word;
                Frame_oe  = 1'b1;
                IRDY_out  = 1'b0;
                IRDY_oe   = 1'b1;
                AD_out    = is_write ? Wr_data : '0;
                AD_oe     = is_write;
                CBE_oe    = 1'b1;
            end
            S_ABORT: begin
                Frame_oe = 1'b1;
                IRDY_out = 1'b0;
                IRDY_oe  = 1'b1;
                CBE_oe   = 1'b1;
            end
            S_TURN: begin
                Frame_oe = 1'b1;
                IRDY_oe  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
